score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper_if.sv | 23 ++
 rtl/score_keeper.sv | 189 ++++++++++++++++++
 tb/tb_score_keeper.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/score_keeper_if.sv
// Event/score bus for score_keeper: piece-lock events in, packed-BCD score out.
interface score_keeper_if;
  logic        clear;
  logic        evt_valid;
  logic [2:0]  evt_lines;
  logic        evt_ready;
  logic [15:0] score;
  logic        score_inc;
  logic [15:0] best;
  logic        busy;

  // Game logic side: offers events and restarts.
  modport master (
    output clear, evt_valid, evt_lines,
    input  evt_ready, score, score_inc, best, busy
  );

  // Score keeper side.
  modport slave (
    input  clear, evt_valid, evt_lines,
    output evt_ready, score, score_inc, best, busy
  );
endinterface

// File: rtl/score_keeper.sv
// Score keeper: turns line-clear events into a 4-digit packed-BCD score.
// One BCD digit is added per cycle (ADD0..ADD3), so an accepted event
// commits exactly four edges later; the score register is only written at
// commit so partial sums never leak out. Overflow past 9999 saturates.

// Single BCD digit adder: a + b + cin, with decimal carry out.
module score_keeper_bcd_digit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] sum;

  // Binary sum, then fold anything above 9 back into a decimal digit.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    s    = sum[3:0];
    cout = 1'b0;
    if (sum > 5'd9) begin
      s    = 4'(sum - 5'd10);
      cout = 1'b1;
    end
  end
endmodule

module score_keeper (
  input  logic          clk,
  input  logic          reset,
  score_keeper_if.slave bus
);
  localparam int NUM_DIGITS = 4;

  typedef enum logic [2:0] {IDLE, ADD0, ADD1, ADD2, ADD3} state_t;

  state_t                          state_q, state_d;
  logic [NUM_DIGITS-1:0][3:0]      work_q;
  logic [NUM_DIGITS-1:0][3:0]      work_upd;
  logic [15:0]                     commit_val;
  logic [15:0]                     score_q;
  logic [15:0]                     best_q;
  logic                            inc_q;
  logic                            carry_q;
  logic [1:0]                      combo_q;
  logic [3:0]                      addend_q;
  logic [3:0]                      addend_d;
  logic [3:0]                      base;
  logic [1:0]                      dig_idx;
  logic [3:0]                      dig_b;
  logic [3:0]                      dig_sum;
  logic                            dig_cout;
  logic                            accept;
  logic                            evt_ready_c;

  // An event offered alongside clear is dropped, even though ready is high.
  assign accept = evt_ready_c && bus.evt_valid && !bus.clear;

  // Points for the lock: base by line count (5..7 behave as a tetris)
  // plus the combo bonus. combo saturates at 3, so max addend is 6+3=9.
  always_comb begin
    case (bus.evt_lines)
      3'd1:    base = 4'd1;
      3'd2:    base = 4'd2;
      3'd3:    base = 4'd4;
      default: base = 4'd6;
    endcase
    addend_d = base + {2'b00, combo_q};
  end

  // Select the digit worked on in this ADD state; only ADD0 adds the addend,
  // later states just ripple the carry.
  always_comb begin
    dig_idx = 2'd0;
    dig_b   = 4'd0;
    case (state_q)
      ADD0: begin dig_idx = 2'd0; dig_b = addend_q; end
      ADD1: dig_idx = 2'd1;
      ADD2: dig_idx = 2'd2;
      ADD3: dig_idx = 2'd3;
      default: begin dig_idx = 2'd0; dig_b = 4'd0; end
    endcase
  end

  score_keeper_bcd_digit u_dig (
    .a    (work_q[dig_idx]),
    .b    (dig_b),
    .cin  (carry_q),
    .s    (dig_sum),
    .cout (dig_cout)
  );

  // Working value with the current digit replaced; at ADD3 a carry out of
  // the top digit means the score went past 9999, so pin it there.
  always_comb begin
    work_upd          = work_q;
    work_upd[dig_idx] = dig_sum;
    commit_val        = dig_cout ? 16'h9999 : work_upd;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: clear wins; scoring events walk the four digits once.
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept && bus.evt_lines != 3'd0) state_d = ADD0;
        ADD0:    state_d = ADD1;
        ADD1:    state_d = ADD2;
        ADD2:    state_d = ADD3;
        ADD3:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: ready only while idle.
  always_comb begin
    evt_ready_c = (state_q == IDLE);
  end

  // Datapath: latch addend on accept, ripple one digit per ADD state,
  // commit score/best and pulse score_inc when leaving ADD3.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work_q   <= '0;
      carry_q  <= 1'b0;
      combo_q  <= 2'd0;
      addend_q <= 4'd0;
      score_q  <= 16'h0000;
      best_q   <= 16'h0000;
      inc_q    <= 1'b0;
    end else if (bus.clear) begin
      // Restart the game; the high score survives.
      work_q   <= '0;
      carry_q  <= 1'b0;
      combo_q  <= 2'd0;
      addend_q <= 4'd0;
      score_q  <= 16'h0000;
      inc_q    <= 1'b0;
    end else begin
      inc_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (bus.evt_lines == 3'd0) begin
              combo_q <= 2'd0;
            end else begin
              addend_q <= addend_d;
              combo_q  <= (combo_q == 2'd3) ? 2'd3 : combo_q + 2'd1;
              work_q   <= score_q;
              carry_q  <= 1'b0;
            end
          end
        end
        ADD0, ADD1, ADD2: begin
          work_q  <= work_upd;
          carry_q <= dig_cout;
        end
        ADD3: begin
          work_q  <= commit_val;
          carry_q <= 1'b0;
          score_q <= commit_val;
          inc_q   <= 1'b1;
          // Packed BCD orders the same as its unsigned binary image.
          if (commit_val > best_q) best_q <= commit_val;
        end
        default: begin
          work_q  <= work_q;
          carry_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.evt_ready = evt_ready_c;
  assign bus.busy      = ~evt_ready_c;
  assign bus.score     = score_q;
  assign bus.score_inc = inc_q;
  assign bus.best      = best_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: decimal reference model, scoreboard of committed
// scores, a vector table for the combo ramp and hand sequences for
// clear/reset corner cases.
module tb_score_keeper;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  score_keeper_if sk();

  score_keeper dut (
    .clk   (clk),
    .reset (rst),
    .bus   (sk)
  );

  int tests  = 0;
  int failed = 0;

  // Reference model state, in plain decimal.
  int combo_m = 0;
  int dec_m   = 0;
  int best_m  = 0;

  logic [15:0] exp_q[$];

  typedef struct {
    logic [2:0]  lines;
    logic [15:0] exp_score;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every score_inc pulse must match the oldest expected commit.
  always @(negedge clk) begin
    if (!rst && sk.score_inc === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL sb_unexpected_inc: got score %h with no commit expected", sk.score);
      end else begin
        chk("sb_score", sk.score, exp_q.pop_front());
      end
    end
  end

  // Offer one event, then track it cycle by cycle to commit.
  task automatic send(input logic [2:0] lines);
    logic [15:0] old;
    int n;
    int add;
    n = 0;
    @(negedge clk);
    while (sk.evt_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) chk("ready_timeout", 16'(sk.evt_ready), 16'd1);
    old = to_bcd(dec_m);
    sk.evt_valid = 1'b1;
    sk.evt_lines = lines;
    if (lines == 3'd0) begin
      combo_m = 0;
    end else begin
      case (lines)
        3'd1:    add = 1;
        3'd2:    add = 2;
        3'd3:    add = 4;
        default: add = 6;
      endcase
      add = add + combo_m;
      combo_m = (combo_m < 3) ? combo_m + 1 : 3;
      dec_m = (dec_m + add > 9999) ? 9999 : dec_m + add;
      if (dec_m > best_m) best_m = dec_m;
      exp_q.push_back(to_bcd(dec_m));
    end
    @(posedge clk);
    #1;
    sk.evt_valid = 1'b0;
    if (lines == 3'd0) begin
      chk("zero_busy", 16'(sk.busy), 16'd0);
      chk("zero_score", sk.score, old);
      chk("zero_inc", 16'(sk.score_inc), 16'd0);
    end else begin
      for (int k = 1; k <= 3; k++) begin
        chk("add_busy", 16'(sk.busy), 16'd1);
        chk("add_score_hold", sk.score, old);
        chk("add_inc_low", 16'(sk.score_inc), 16'd0);
        @(posedge clk);
        #1;
      end
      chk("add_busy3", 16'(sk.busy), 16'd1);
      @(posedge clk);
      #1;
      chk("commit_score", sk.score, to_bcd(dec_m));
      chk("commit_inc", 16'(sk.score_inc), 16'd1);
      chk("commit_ready", 16'(sk.evt_ready), 16'd1);
      chk("commit_best", sk.best, to_bcd(best_m));
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    sk.clear = 1'b1;
    @(posedge clk);
    #1;
    sk.clear = 1'b0;
    dec_m = 0;
    combo_m = 0;
    chk("clear_score", sk.score, 16'h0000);
    chk("clear_best", sk.best, to_bcd(best_m));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{3'd4, 16'h0006};
    tbl[1] = '{3'd4, 16'h0013};
    tbl[2] = '{3'd4, 16'h0021};
    tbl[3] = '{3'd4, 16'h0030};
    tbl[4] = '{3'd0, 16'h0030};
    tbl[5] = '{3'd1, 16'h0031};
    tbl[6] = '{3'd7, 16'h0038};
    tbl[7] = '{3'd2, 16'h0042};
    tbl[8] = '{3'd3, 16'h0049};
    tbl[9] = '{3'd5, 16'h0058};

    sk.clear = 1'b0;
    sk.evt_valid = 1'b0;
    sk.evt_lines = 3'd0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_score", sk.score, 16'h0000);
    chk("rst_best", sk.best, 16'h0000);
    chk("rst_ready", 16'(sk.evt_ready), 16'd1);
    chk("rst_busy", 16'(sk.busy), 16'd0);
    chk("rst_inc", 16'(sk.score_inc), 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single event.
    send(3'd1);
    chk("single_score", sk.score, 16'h0001);
    @(posedge clk);
    #1;
    chk("single_inc_drop", 16'(sk.score_inc), 16'd0);

    // Combo ramp and line-count table from a fresh game.
    do_clear();
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].lines);
      chk("tbl_score", sk.score, tbl[i].exp_score);
    end
    chk("tbl_best", sk.best, 16'h0058);

    // Carry chain: build 0999, then add 2.
    do_clear();
    repeat (3) send(3'd4);
    repeat (108) send(3'd4);
    send(3'd0);
    send(3'd4);
    chk("pre_999", sk.score, 16'h0999);
    send(3'd1);
    chk("carry_1001", sk.score, 16'h1001);

    // Saturation: build 9995 with combo at 3, then add 9 twice.
    do_clear();
    repeat (3) send(3'd4);
    send(3'd1);
    send(3'd3);
    repeat (1107) send(3'd4);
    chk("pre_9995", sk.score, 16'h9995);
    send(3'd4);
    chk("sat_9999", sk.score, 16'h9999);
    send(3'd4);
    chk("sat_hold", sk.score, 16'h9999);
    chk("sat_best", sk.best, 16'h9999);

    // Clear mid-addition at ADD2: abort, no commit.
    do_clear();
    send(3'd1);
    @(negedge clk);
    sk.evt_valid = 1'b1;
    sk.evt_lines = 3'd2;
    @(posedge clk);
    #1;
    sk.evt_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    sk.clear = 1'b1;
    @(posedge clk);
    #1;
    sk.clear = 1'b0;
    dec_m = 0;
    combo_m = 0;
    chk("abort_ready", 16'(sk.evt_ready), 16'd1);
    chk("abort_score", sk.score, 16'h0000);
    chk("abort_best", sk.best, 16'h9999);
    @(posedge clk);
    #1;
    chk("abort_no_inc", 16'(sk.score_inc), 16'd0);
    chk("abort_score2", sk.score, 16'h0000);

    // Event alongside clear is dropped.
    @(negedge clk);
    sk.clear = 1'b1;
    sk.evt_valid = 1'b1;
    sk.evt_lines = 3'd1;
    @(posedge clk);
    #1;
    sk.clear = 1'b0;
    sk.evt_valid = 1'b0;
    chk("clr_evt_busy", 16'(sk.busy), 16'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("clr_evt_score", sk.score, 16'h0000);

    // Async reset mid-ADD1.
    send(3'd1);
    @(negedge clk);
    sk.evt_valid = 1'b1;
    sk.evt_lines = 3'd1;
    @(posedge clk);
    #1;
    sk.evt_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_score", sk.score, 16'h0000);
    chk("arst_best", sk.best, 16'h0000);
    chk("arst_ready", 16'(sk.evt_ready), 16'd1);
    chk("arst_busy", 16'(sk.busy), 16'd0);
    chk("arst_inc", 16'(sk.score_inc), 16'd0);
    exp_q.delete();
    dec_m = 0;
    combo_m = 0;
    best_m = 0;
    @(negedge clk);
    rst = 1'b0;
    send(3'd1);
    chk("post_rst_score", sk.score, 16'h0001);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 16'(exp_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
